uart_rx_os: RTL
===============

# uart_rx_os

Oversampling UART receiver with runtime-independent framing parameters, optional parity, one or two stop bits, and error/break detection. It replaces the fixed center-sample receiver on the host link. Received words go to a one-entry output buffer with a valid/ready handshake, so downstream logic (host FIFO, command decoder) can apply backpressure. Overrun is reported, not hidden.

## Interface
- clk_per_tick_p, 4: clocks per oversample tick (≥1); baud = f_clk / (clk_per_tick_p · os_ratio_p)
- os_ratio_p, 16: oversample ticks per bit (8 or 16)
- data_bits_p, 8: data bits per frame (5..9), LSB first
- parity_p, 0: 0 none, 1 odd, 2 even
- stop_bits_p, 1: 1 or 2
- sync_stages_p, 2: rx_i synchronizer depth (≥2)

- clk_i  in  1  sole clock
- reset_n_i  in  1  asynchronous, active-low reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- rx_data_o  out  data_bits_p  received word; stable while rx_v_o=1
- rx_v_o  out  1  word valid
- rx_ready_i  in  1  consumer accepts; transfer when rx_v_o & rx_ready_i
- parity_err_o  out  1  parity mismatch for the buffered word (0 when parity_p=0)
- frame_err_o  out  1  any stop-bit sample low for the buffered word
- break_o  out  1  buffered word is a break (data, parity and stop all 0)
- overrun_o  out  1  one-cycle pulse: completed word dropped because buffer full
- busy_o  out  1  receiver not in IDLE

## Operation
- rx_i passes through sync_stages_p flops; all logic uses the synchronized value rx_s.
- Tick generator: counter 0..clk_per_tick_p-1, reset to 0 while in IDLE; tick asserts when counter wraps. Bit-phase counter 0..os_ratio_p-1 advances on ticks.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: falling edge of rx_s → START, counters cleared.
- START: at phase os_ratio_p/2, sample; 1 → IDLE (glitch rejected, nothing emitted); 0 → continue. At phase os_ratio_p-1 → DATA.
- DATA: sample each bit at mid-phase into shift register (LSB first); after data_bits_p bits → PARITY if parity_p≠0, else STOP.
- PARITY: sample; parity_err = (XOR of data ^ sampled bit) != (parity_p==1).
- STOP: sample each stop bit at mid-phase. At the last stop sample, the word with flags is committed. If the last stop sample is 1 → IDLE immediately (no wait for end of bit); otherwise → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE. A break holding the line low emits exactly one word.
- Commit: if buffer empty, or being drained in the same cycle (rx_v_o & rx_ready_i), load data and flags and set rx_v_o. Otherwise drop the word, keep old contents, and pulse overrun_o.
- break_o = frame_err & data==0 & (parity bit sampled 0 or parity_p=0).

## Timing
- Reset: all outputs 0, state IDLE, buffer empty, counters 0; an asserted reset aborts any frame in progress. After release, a line already low is not treated as a start bit until a falling edge is seen.
- Sample point: mid-phase tick (phase os_ratio_p/2).
- Latency: rx_v_o rises 1 clk after the commit tick. The commit tick is (1 + data_bits_p + (parity_p≠0) + stop_bits_p − 1) · os_ratio_p + os_ratio_p/2 ticks after the detected falling edge, plus sync_stages_p+1 clks from the rx_i edge.
- rx_v_o falls the cycle after acceptance, unless a commit coincides with acceptance; in that case it stays high with the new word.
- overrun_o is high for exactly 1 clk per dropped word.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample is the majority of phases os_ratio_p/2−1, os_ratio_p/2 and os_ratio_p/2+1. The decision is taken at the +1 phase, which shifts commit by 1 tick.
- Undefined: single sample at phase os_ratio_p/2.

## Test plan
Defaults unless stated: clk_per_tick_p=4, os_ratio_p=16, so 64 clk/bit.
- Send 0xA5, 8N1 → rx_v_o with rx_data_o=0xA5; all error flags 0; rx_v_o holds until rx_ready_i=1, then drops next clk.
- parity_p=2, send 0x03 with parity bit 1 → parity_err_o=1, data 0x03. Same with parity bit 0 → parity_err_o=0.
- Send 0x5A with stop bit driven 0, then line high after 3 bit times → frame_err_o=1, break_o=0. A following 0x3C is received cleanly.
- Hold line low 20 bit times → exactly one word: data 0x00, frame_err_o=1, break_o=1. No further word until the line goes high and a new frame starts.
- Low glitch of 5 ticks → no rx_v_o, busy_o returns 0. Reset asserted mid-frame → outputs 0, no word emitted.
- rx_ready_i=0; send 0x11 then 0x22 → rx_data_o stays 0x11, overrun_o pulses once. With UART_RX_MAJORITY_EN, a 1-tick inverted glitch at mid-phase of bit 3 of 0xFF still yields 0xFF.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-entry valid/ready output buffer.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around mid-bit.
module uart_rx_os #(
    parameter int unsigned clk_per_tick_p = 4,
    parameter int unsigned os_ratio_p     = 16,
    parameter int unsigned data_bits_p    = 8,
    parameter int unsigned parity_p       = 0,
    parameter int unsigned stop_bits_p    = 1,
    parameter int unsigned sync_stages_p  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   rx_i,
    output logic [data_bits_p-1:0] rx_data_o,
    output logic                   rx_v_o,
    input  logic                   rx_ready_i,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   break_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int unsigned TK_W = (clk_per_tick_p > 1) ? $clog2(clk_per_tick_p) : 1;
    localparam int unsigned PH_W = $clog2(os_ratio_p);
    localparam int unsigned BC_W = $clog2(data_bits_p + 1);
    localparam int unsigned MID  = os_ratio_p / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic [sync_stages_p-1:0] sync_q;
    logic                     rx_s;
    logic                     rx_prev_q;
    logic                     fall;

    logic [TK_W-1:0]          tick_cnt_q;
    logic [PH_W-1:0]          phase_q;
    logic                     tick;
    logic                     bit_end;
    logic                     samp_en;
    logic                     samp_bit;

    logic [BC_W-1:0]          bit_cnt_q;
    logic [data_bits_p-1:0]   shreg_q;
    logic                     par_q;
    logic                     stop_cnt_q;
    logic                     stop_low_q;
    logic                     commit;

    logic                     frame_now;
    logic                     perr_now;
    logic                     brk_now;

    // Reset to 0 so a line already low at release never looks like a falling edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q    <= '0;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[sync_stages_p-2:0], rx_i};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[sync_stages_p-1];
    assign fall = rx_prev_q & ~rx_s;

    assign tick    = (tick_cnt_q == TK_W'(clk_per_tick_p - 1));
    assign bit_end = tick && (phase_q == PH_W'(os_ratio_p - 1));

    // A sample "at phase p" is taken on the tick that moves the counter to p.
`ifdef UART_RX_MAJORITY_EN
    logic maj_a_q, maj_b_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            maj_a_q <= 1'b0;
            maj_b_q <= 1'b0;
        end else begin
            if (tick && (phase_q == PH_W'(MID - 2))) maj_a_q <= rx_s;
            if (tick && (phase_q == PH_W'(MID - 1))) maj_b_q <= rx_s;
        end
    end

    assign samp_en  = tick && (phase_q == PH_W'(MID));
    assign samp_bit = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
`else
    assign samp_en  = tick && (phase_q == PH_W'(MID - 1));
    assign samp_bit = rx_s;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (samp_en && samp_bit) state_d = S_IDLE;
                else if (bit_end)        state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_cnt_q == BC_W'(data_bits_p - 1)))
                    state_d = (parity_p != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (samp_en && (stop_cnt_q == (stop_bits_p == 2))) begin
                    commit  = 1'b1;
                    state_d = samp_bit ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tick_cnt_q <= '0;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            stop_low_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                tick_cnt_q <= '0;
                phase_q    <= '0;
            end else if (tick) begin
                tick_cnt_q <= '0;
                phase_q    <= phase_q + PH_W'(1);
            end else begin
                tick_cnt_q <= tick_cnt_q + TK_W'(1);
            end

            if (state_q != S_DATA)  bit_cnt_q <= '0;
            else if (bit_end)       bit_cnt_q <= bit_cnt_q + BC_W'(1);

            if ((state_q == S_DATA) && samp_en)
                shreg_q <= {samp_bit, shreg_q[data_bits_p-1:1]};

            if ((state_q == S_PARITY) && samp_en)
                par_q <= samp_bit;

            if (state_q != S_STOP) begin
                stop_cnt_q <= 1'b0;
                stop_low_q <= 1'b0;
            end else begin
                if (bit_end)              stop_cnt_q <= 1'b1;
                if (samp_en && !samp_bit) stop_low_q <= 1'b1;
            end
        end
    end

    assign frame_now = stop_low_q | ~samp_bit;
    assign perr_now  = (parity_p != 0) && ((^shreg_q ^ par_q) != (parity_p == 1));
    assign brk_now   = frame_now && (shreg_q == '0) && ((parity_p == 0) || !par_q);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_data_o    <= '0;
            rx_v_o       <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (commit) begin
                if (!rx_v_o || rx_ready_i) begin
                    rx_data_o    <= shreg_q;
                    rx_v_o       <= 1'b1;
                    parity_err_o <= perr_now;
                    frame_err_o  <= frame_now;
                    break_o      <= brk_now;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_v_o && rx_ready_i) begin
                rx_v_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule
